m68k_bus_initiator: RTL

- Synchronous 68000-style bus master that generates asynchronous bus cycles on the Amiga CPU-side bus (A, D, _AS, _UDS, _LDS, _PRW, _DTACK).
- These are the cycles that the daughterboard WCS/Kickstart RAM and the other bus responders answer.
- Used by bench CPU models and by the boot loader that writes the Kickstart image into daughterboard RAM before write-protect is set.
- Presents a simple request/done interface on the host side. One clock equals one 68000 half-clock state (S0..S7).

---
 rtl/m68k_bus_initiator_if.sv | 68 ++++++
 rtl/m68k_bus_initiator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_initiator_if.sv
// Host request/done bundle plus the 68000-style CPU-side bus
// of m68k_bus_initiator.
interface m68k_bus_initiator_if;

  logic        REQ;
  logic        WE;
  logic [22:0] ADDR;
  logic [15:0] WDATA;
  logic [1:0]  BE;

  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] RDATA;

  logic [22:0] A;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN;
  logic        _AS;
  logic        _UDS;
  logic        _LDS;
  logic        _PRW;
  logic        _DTACK;

  modport master (
    input  REQ,
    input  WE,
    input  ADDR,
    input  WDATA,
    input  BE,
    output BUSY,
    output DONE,
    output ERR,
    output RDATA,
    output A,
    output D_OUT,
    output D_OE,
    input  D_IN,
    output _AS,
    output _UDS,
    output _LDS,
    output _PRW,
    input  _DTACK
  );

  modport slave (
    output REQ,
    output WE,
    output ADDR,
    output WDATA,
    output BE,
    input  BUSY,
    input  DONE,
    input  ERR,
    input  RDATA,
    input  A,
    input  D_OUT,
    input  D_OE,
    output D_IN,
    input  _AS,
    input  _UDS,
    input  _LDS,
    input  _PRW,
    output _DTACK
  );

endinterface

// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus cycle generator, one C7M edge per
// S-state, with _DTACK wait pairs, timeout abort and DONE/ERR reporting.
module m68k_bus_initiator #(
  parameter int TIMEOUT_WAITS = 16
) (
  input  logic C7M,
  input  logic _RST,
  m68k_bus_initiator_if.master bus
);

  localparam logic [7:0] LIM = 8'(TIMEOUT_WAITS);

  typedef enum logic [3:0] {
    IDLE,
    S0,
    S1,
    S2,
    S3,
    S4,
    S5,
    S6,
    S7,
    W0,
    W1,
    BAD
  } st_t;

  st_t r_st;
  st_t w_nxt;

  logic        r_we;
  logic [22:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_be;
  logic [7:0]  r_cnt;
  logic        r_abt;
  logic        r_fin;

  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_rdata;
  logic [22:0] r_a;
  logic [15:0] r_dout;
  logic        r_doe;
  logic        r_as;
  logic        r_uds;
  logic        r_lds;
  logic        r_prw;

  logic w_acc;
  logic w_samp;
  logic w_fail;
  logic w_tmo;

  logic w_addr_on;
  logic w_as_on;
  logic w_ds_on;
  logic w_drv;
  logic w_cap;

  assign w_acc  = (r_st == IDLE) && !r_busy && bus.REQ;
  // W1 re-samples _DTACK so each wait pair costs two edges
  assign w_samp = (r_st == S4) || ((r_st == W1) && !r_abt);
  assign w_fail = w_samp && bus._DTACK;
  assign w_tmo  = w_fail && (r_cnt >= LIM);

  always_ff @(posedge C7M) begin
    if (!_RST) begin
      r_st <= IDLE;
    end else begin
      r_st <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      IDLE: begin
        if (w_acc) begin
          w_nxt = (bus.BE == 2'b00) ? BAD : S0;
        end
      end
      S0: w_nxt = S1;
      S1: w_nxt = S2;
      S2: w_nxt = S3;
      S3: w_nxt = S4;
      S4: w_nxt = w_fail ? W0 : S5;
      W0: w_nxt = W1;
      W1: begin
        if (r_abt) begin
          w_nxt = S7;
        end else if (w_fail) begin
          w_nxt = W0;
        end else begin
          w_nxt = S5;
        end
      end
      S5:  w_nxt = S6;
      S6:  w_nxt = S7;
      S7:  w_nxt = IDLE;
      BAD: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Bus enables are decoded from the state being entered
  always_comb begin
    w_addr_on = 1'b0;
    w_as_on   = 1'b0;
    w_ds_on   = 1'b0;
    w_drv     = 1'b0;
    unique case (w_nxt)
      S1: begin
        w_addr_on = 1'b1;
      end
      S2: begin
        w_addr_on = 1'b1;
        w_as_on   = 1'b1;
        w_ds_on   = !r_we;
      end
      S3: begin
        w_addr_on = 1'b1;
        w_as_on   = 1'b1;
        w_ds_on   = !r_we;
        w_drv     = r_we;
      end
      S4, S5, S6, W0, W1: begin
        w_addr_on = 1'b1;
        w_as_on   = 1'b1;
        w_ds_on   = 1'b1;
        w_drv     = r_we;
      end
      S7: begin
        w_addr_on = 1'b1;
        w_drv     = r_we && !r_abt;
      end
      default: begin
        w_addr_on = 1'b0;
      end
    endcase
  end

  assign w_cap = (r_st == S6) && !r_we;

  always_ff @(posedge C7M) begin
    if (!_RST) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_abt   <= 1'b0;
      r_fin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_a     <= '0;
      r_dout  <= '0;
      r_doe   <= 1'b0;
      r_as    <= 1'b1;
      r_uds   <= 1'b1;
      r_lds   <= 1'b1;
      r_prw   <= 1'b1;
    end else begin
      if (w_acc) begin
        r_we    <= bus.WE;
        r_addr  <= bus.ADDR;
        r_wdata <= bus.WDATA;
        r_be    <= bus.BE;
        r_cnt   <= '0;
        r_abt   <= (bus.BE == 2'b00);
      end else if (w_tmo) begin
        r_abt <= 1'b1;
      end else if (w_fail && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end

      r_fin  <= (w_nxt == IDLE) && ((r_st == S7) || (r_st == BAD));
      r_done <= r_fin;
      r_err  <= r_fin && r_abt;

      if (w_acc) begin
        r_busy <= 1'b1;
      end else if (r_fin) begin
        r_busy <= 1'b0;
      end

      if (w_cap) begin
        r_rdata <= bus.D_IN;
      end
      if (w_addr_on) begin
        r_a <= r_addr;
      end
      if (w_drv) begin
        r_dout <= r_wdata;
      end

      r_doe <= w_drv;
      r_prw <= !(w_addr_on && r_we);
      r_as  <= !w_as_on;
      r_uds <= !(w_ds_on && r_be[1]);
      r_lds <= !(w_ds_on && r_be[0]);
    end
  end

  assign bus.BUSY  = r_busy;
  assign bus.DONE  = r_done;
  assign bus.ERR   = r_err;
  assign bus.RDATA = r_rdata;
  assign bus.A     = r_a;
  assign bus.D_OUT = r_dout;
  assign bus.D_OE  = r_doe;
  assign bus._AS   = r_as;
  assign bus._UDS  = r_uds;
  assign bus._LDS  = r_lds;
  assign bus._PRW  = r_prw;

endmodule
